// File: rtl/atm_txn_scheduler.sv
// Round-robin arbiter and atomic transaction engine over a three-entry balance table.
// Every transaction takes IDLE -> LOOKUP -> EXEC -> RESP, so one completes every four cycles.
module atm_txn_scheduler #(
    parameter int N_TERM = 4,
    parameter int ACCT_W = 12,
    parameter int BAL_W  = 12,
    parameter int AMT_W  = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_TERM-1:0]          req,
    input  logic [3*N_TERM-1:0]        op,
    input  logic [ACCT_W*N_TERM-1:0]   acct,
    input  logic [ACCT_W*N_TERM-1:0]   dst,
    input  logic [AMT_W*N_TERM-1:0]    amount,
    output logic [N_TERM-1:0]          grant,
    output logic [N_TERM-1:0]          done,
    output logic                       busy,
    output logic [2:0]                 rsp_status,
    output logic [BAL_W-1:0]           rsp_balance,
    output logic [BAL_W-1:0]           rsp_dst_balance
);

    localparam int PTR_W  = (N_TERM > 1) ? $clog2(N_TERM) : 1;
    localparam int N_ACCT = 3;

    localparam logic [2:0] OP_DEP = 3'd0;
    localparam logic [2:0] OP_WDR = 3'd1;
    localparam logic [2:0] OP_QRY = 3'd2;
    localparam logic [2:0] OP_XFR = 3'd3;

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_BAD_ACCT = 3'd1;
    localparam logic [2:0] ST_BAD_DST  = 3'd2;
    localparam logic [2:0] ST_NSF      = 3'd3;
    localparam logic [2:0] ST_OVF      = 3'd4;
    localparam logic [2:0] ST_BAD_OP   = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_EXEC,
        S_RESP
    } state_t;

    function automatic logic [ACCT_W-1:0] acct_num(input int k);
        case (k)
            0:       acct_num = ACCT_W'(32'h123);
            1:       acct_num = ACCT_W'(32'h456);
            default: acct_num = ACCT_W'(32'h789);
        endcase
    endfunction

    function automatic logic [BAL_W-1:0] bal_rst(input int k);
        case (k)
            0:       bal_rst = BAL_W'(32'h457);
            1:       bal_rst = BAL_W'(32'h8AE);
            default: bal_rst = BAL_W'(32'hD05);
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [2:0]          op_q, op_d;
    logic [ACCT_W-1:0]   acct_q, acct_d;
    logic [ACCT_W-1:0]   dst_q, dst_d;
    logic [AMT_W-1:0]    amt_q, amt_d;
    logic                src_hit_q, src_hit_d;
    logic                dst_hit_q, dst_hit_d;
    logic [1:0]          src_idx_q, src_idx_d;
    logic [1:0]          dst_idx_q, dst_idx_d;
    logic [BAL_W-1:0]    bal_q [N_ACCT];
    logic [BAL_W-1:0]    bal_d [N_ACCT];
    logic [2:0]          rsp_status_q, rsp_status_d;
    logic [BAL_W-1:0]    rsp_bal_q, rsp_bal_d;
    logic [BAL_W-1:0]    rsp_dbal_q, rsp_dbal_d;

    logic [2:0]          op_arr   [N_TERM];
    logic [ACCT_W-1:0]   acct_arr [N_TERM];
    logic [ACCT_W-1:0]   dst_arr  [N_TERM];
    logic [AMT_W-1:0]    amt_arr  [N_TERM];
    logic [PTR_W:0]      cand_sum [N_TERM];
    logic [PTR_W-1:0]    cand_idx [N_TERM];
    logic [N_TERM-1:0]   cand_req;
    logic                arb_found;
    logic [PTR_W-1:0]    arb_idx;

    logic [N_ACCT-1:0]   src_match, dst_match;

    logic [BAL_W-1:0]    src_bal, dst_bal, amt_ext, new_src;
    logic [BAL_W:0]      sum_src, sum_dst;
    logic                is_dep, is_wdr, is_qry, is_xfr;
    logic [2:0]          exec_status;
    logic                exec_ok;

    // Candidate k is the k-th terminal at or after ptr, wrapping at N_TERM.
    for (genvar gi = 0; gi < N_TERM; gi++) begin : g_term
        assign op_arr[gi]   = op[3*gi +: 3];
        assign acct_arr[gi] = acct[ACCT_W*gi +: ACCT_W];
        assign dst_arr[gi]  = dst[ACCT_W*gi +: ACCT_W];
        assign amt_arr[gi]  = amount[AMT_W*gi +: AMT_W];
        assign cand_sum[gi] = {1'b0, ptr_q} + (PTR_W+1)'(gi);
        assign cand_idx[gi] = (cand_sum[gi] >= (PTR_W+1)'(N_TERM))
                            ? PTR_W'(cand_sum[gi] - (PTR_W+1)'(N_TERM))
                            : cand_sum[gi][PTR_W-1:0];
        assign cand_req[gi] = req[cand_idx[gi]];
        assign grant[gi]    = busy && (win_q == PTR_W'(gi));
        assign done[gi]     = (state_q == S_RESP) && (win_q == PTR_W'(gi));
    end

    for (genvar gi = 0; gi < N_ACCT; gi++) begin : g_match
        assign src_match[gi] = (acct_q == acct_num(gi));
        assign dst_match[gi] = (dst_q == acct_num(gi));
    end

    assign busy            = (state_q != S_IDLE);
    assign rsp_status      = rsp_status_q;
    assign rsp_balance     = rsp_bal_q;
    assign rsp_dst_balance = rsp_dbal_q;
    assign amt_ext         = BAL_W'(amt_q);

    always_comb begin
        arb_found = |cand_req;
        arb_idx   = '0;
        for (int k = N_TERM - 1; k >= 0; k--) begin
            if (cand_req[k]) arb_idx = cand_idx[k];
        end
    end

    // EXEC datapath: sums are one bit wider so overflow is seen instead of wrapping.
    always_comb begin
        src_bal = '0;
        dst_bal = '0;
        for (int k = 0; k < N_ACCT; k++) begin
            if (src_idx_q == 2'(k)) src_bal = bal_q[k];
            if (dst_idx_q == 2'(k)) dst_bal = bal_q[k];
        end
        sum_src = {1'b0, src_bal} + {1'b0, amt_ext};
        sum_dst = {1'b0, dst_bal} + {1'b0, amt_ext};
        is_dep  = (op_q == OP_DEP);
        is_wdr  = (op_q == OP_WDR);
        is_qry  = (op_q == OP_QRY);
        is_xfr  = (op_q == OP_XFR);

        new_src = src_bal;
        if (is_dep)               new_src = sum_src[BAL_W-1:0];
        else if (is_wdr || is_xfr) new_src = src_bal - amt_ext;

        exec_status = ST_OK;
        if (op_q[2] || (!is_qry && (amt_q == '0)))
            exec_status = ST_BAD_OP;
        else if (!src_hit_q)
            exec_status = ST_BAD_ACCT;
        else if (is_xfr && (!dst_hit_q || (dst_idx_q == src_idx_q)))
            exec_status = ST_BAD_DST;
        else if ((is_wdr || is_xfr) && (amt_ext > src_bal))
            exec_status = ST_NSF;
        else if ((is_dep && sum_src[BAL_W]) || (is_xfr && sum_dst[BAL_W]))
            exec_status = ST_OVF;
        exec_ok = (exec_status == ST_OK);
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        win_d        = win_q;
        op_d         = op_q;
        acct_d       = acct_q;
        dst_d        = dst_q;
        amt_d        = amt_q;
        src_hit_d    = src_hit_q;
        dst_hit_d    = dst_hit_q;
        src_idx_d    = src_idx_q;
        dst_idx_d    = dst_idx_q;
        rsp_status_d = rsp_status_q;
        rsp_bal_d    = rsp_bal_q;
        rsp_dbal_d   = rsp_dbal_q;
        for (int k = 0; k < N_ACCT; k++) bal_d[k] = bal_q[k];

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    win_d   = arb_idx;
                    op_d    = op_arr[arb_idx];
                    acct_d  = acct_arr[arb_idx];
                    dst_d   = dst_arr[arb_idx];
                    amt_d   = amt_arr[arb_idx];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                src_hit_d = |src_match;
                dst_hit_d = |dst_match;
                src_idx_d = '0;
                dst_idx_d = '0;
                for (int k = 0; k < N_ACCT; k++) begin
                    if (src_match[k]) src_idx_d = 2'(k);
                    if (dst_match[k]) dst_idx_d = 2'(k);
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                rsp_status_d = exec_status;
                rsp_bal_d    = exec_ok ? new_src : (src_hit_q ? src_bal : '0);
                rsp_dbal_d   = (exec_ok && is_xfr) ? sum_dst[BAL_W-1:0] : '0;
                if (exec_ok) begin
                    for (int k = 0; k < N_ACCT; k++) begin
                        if ((src_idx_q == 2'(k)) && !is_qry) bal_d[k] = new_src;
                        if ((dst_idx_q == 2'(k)) && is_xfr)  bal_d[k] = sum_dst[BAL_W-1:0];
                    end
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                ptr_d   = (win_q == PTR_W'(N_TERM - 1)) ? '0 : win_q + PTR_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            win_q        <= '0;
            op_q         <= '0;
            acct_q       <= '0;
            dst_q        <= '0;
            amt_q        <= '0;
            src_hit_q    <= 1'b0;
            dst_hit_q    <= 1'b0;
            src_idx_q    <= '0;
            dst_idx_q    <= '0;
            rsp_status_q <= '0;
            rsp_bal_q    <= '0;
            rsp_dbal_q   <= '0;
            for (int k = 0; k < N_ACCT; k++) bal_q[k] <= bal_rst(k);
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            op_q         <= op_d;
            acct_q       <= acct_d;
            dst_q        <= dst_d;
            amt_q        <= amt_d;
            src_hit_q    <= src_hit_d;
            dst_hit_q    <= dst_hit_d;
            src_idx_q    <= src_idx_d;
            dst_idx_q    <= dst_idx_d;
            rsp_status_q <= rsp_status_d;
            rsp_bal_q    <= rsp_bal_d;
            rsp_dbal_q   <= rsp_dbal_d;
            for (int k = 0; k < N_ACCT; k++) bal_q[k] <= bal_d[k];
        end
    end

endmodule

// File: tb/tb_atm_txn_scheduler.sv
// Bench for atm_txn_scheduler: directed vector table, multi-cycle corner sequences,
// and randomized transactions checked against an account-table model.
module tb_atm_txn_scheduler;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int BW = 12;
    localparam int MW = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [3*N-1:0]    op_v = '0;
    logic [AW*N-1:0]   acct_v = '0;
    logic [AW*N-1:0]   dst_v = '0;
    logic [MW*N-1:0]   amt_v = '0;
    logic [N-1:0]      grant, done;
    logic              busy;
    logic [2:0]        rsp_status;
    logic [BW-1:0]     rsp_balance, rsp_dst_balance;

    atm_txn_scheduler #(.N_TERM(N), .ACCT_W(AW), .BAL_W(BW), .AMT_W(MW)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op_v), .acct(acct_v), .dst(dst_v),
        .amount(amt_v), .grant(grant), .done(done), .busy(busy),
        .rsp_status(rsp_status), .rsp_balance(rsp_balance),
        .rsp_dst_balance(rsp_dst_balance)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: account list plus balances, rules applied directly as arithmetic.
    int m_acct [3] = '{'h123, 'h456, 'h789};
    int m_bal  [3];

    typedef struct {
        int term; int op; int acct; int dst; int amt;
        int st; int bal; int dbal;
    } vec_t;
    vec_t vecs [10];

    function automatic void model_reset();
        m_bal[0] = 'h457; m_bal[1] = 'h8AE; m_bal[2] = 'hD05;
    endfunction

    function automatic void model(input int o, input int a, input int d, input int amt,
                                  output int st, output int b, output int db);
        int si = -1;
        int di = -1;
        for (int k = 0; k < 3; k++) begin
            if (m_acct[k] == a) si = k;
            if (m_acct[k] == d) di = k;
        end
        st = 0;
        if (o > 3 || (o != 2 && amt == 0))                     st = 5;
        else if (si < 0)                                       st = 1;
        else if (o == 3 && (di < 0 || di == si))               st = 2;
        else if ((o == 1 || o == 3) && amt > m_bal[si])        st = 3;
        else if (o == 0 && m_bal[si] + amt > 4095)             st = 4;
        else if (o == 3 && m_bal[di] + amt > 4095)             st = 4;
        if (st == 0) begin
            if (o == 0) m_bal[si] += amt;
            if (o == 1) m_bal[si] -= amt;
            if (o == 3) begin m_bal[si] -= amt; m_bal[di] += amt; end
        end
        b  = (si < 0) ? 0 : m_bal[si];
        db = (st == 0 && o == 3) ? m_bal[di] : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One transaction from terminal t; returns DUT response and model expectation.
    task automatic do_txn(input int t, input int o, input int a, input int d, input int amt,
                          output int st, output int b, output int db,
                          output int mst, output int mb, output int mdb);
        int g = -1;
        int dn = -1;
        st = -1; b = -1; db = -1;
        @(posedge clk); #1;
        op_v[3*t +: 3]     = 3'(o);
        acct_v[AW*t +: AW] = AW'(a);
        dst_v[AW*t +: AW]  = AW'(d);
        amt_v[MW*t +: MW]  = MW'(amt);
        req[t] = 1'b1;
        for (int n = 0; n < 20 && dn < 0; n++) begin
            @(negedge clk);
            if (g < 0 && grant[t]) begin
                g = n;
                check("grant_onehot", int'(grant), 1 << t);
            end
            if (done[t]) begin
                dn = n;
                st = int'(rsp_status);
                b  = int'(rsp_balance);
                db = int'(rsp_dst_balance);
            end
        end
        req[t] = 1'b0;
        check("done_seen", int'(dn >= 0), 1);
        if (dn >= 0) check("grant_to_done", dn - g, 2);
        model(o, a, d, amt, mst, mb, mdb);
        $display("txn term=%0d op=%0d acct=%0h dst=%0h amt=%0h -> status=%0d bal=%0h dst_bal=%0h",
                 t, o, a, d, amt, st, b, db);
    endtask

    task automatic txn_const(input string name, input int t, input int o, input int a,
                             input int d, input int amt, input int est, input int eb, input int edb);
        int st, b, db, mst, mb, mdb;
        do_txn(t, o, a, d, amt, st, b, db, mst, mb, mdb);
        check({name, "_status"}, st, est);
        check({name, "_bal"}, b, eb);
        check({name, "_dbal"}, db, edb);
    endtask

    task automatic txn_model(input string name, input int t, input int o, input int a,
                             input int d, input int amt);
        int st, b, db, mst, mb, mdb;
        do_txn(t, o, a, d, amt, st, b, db, mst, mb, mdb);
        check({name, "_status"}, st, mst);
        check({name, "_bal"}, b, mb);
        check({name, "_dbal"}, db, mdb);
    endtask

    function automatic int pick_acct();
        int k = $urandom_range(0, 3);
        return (k == 3) ? 'h999 : m_acct[k];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 3, 'h123, 'h789, 'h20, 0, 'h437, 'hD25};
        vecs[1] = '{1, 2, 'h789, 'h000, 'h00, 0, 'hD25, 0};
        vecs[2] = '{2, 0, 'h999, 'h000, 'h05, 1, 0, 0};
        vecs[3] = '{3, 3, 'h123, 'h123, 'h01, 2, 'h437, 0};
        vecs[4] = '{0, 7, 'h123, 'h000, 'h04, 5, 'h437, 0};
        vecs[5] = '{1, 0, 'h123, 'h000, 'h00, 5, 'h437, 0};
        vecs[6] = '{2, 3, 'h456, 'h999, 'h01, 2, 'h8AE, 0};
        vecs[7] = '{3, 1, 'h456, 'h000, 'h3F, 0, 'h86F, 0};
        vecs[8] = '{0, 2, 'h123, 'h000, 'h00, 0, 'h437, 0};
        vecs[9] = '{1, 2, 'h789, 'h000, 'h00, 0, 'hD25, 0};

        // Reset state while rst is held.
        repeat (2) @(negedge clk);
        check("rst_grant", int'(grant), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rsp", int'({rsp_status, rsp_balance, rsp_dst_balance}), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 10; i++)
            txn_const($sformatf("vec%0d", i), vecs[i].term, vecs[i].op, vecs[i].acct,
                      vecs[i].dst, vecs[i].amt, vecs[i].st, vecs[i].bal, vecs[i].dbal);

        apply_reset();
        txn_const("withdraw", 0, 1, 'h123, 0, 'h10, 0, 'h447, 0);

        // NSF boundary: 17 withdrawals of 0x3F fit, the 18th does not.
        apply_reset();
        for (int i = 0; i < 17; i++) txn_model("nsf_run", i % N, 1, 'h123, 0, 'h3F);
        txn_const("nsf_last_ok", 1, 2, 'h123, 0, 0, 0, 'h028, 0);
        txn_const("nsf", 2, 1, 'h123, 0, 'h3F, 3, 'h028, 0);

        // Overflow boundary at 0xFFF, for deposit and transfer destination.
        apply_reset();
        for (int i = 0; i < 12; i++) txn_model("ovf_run", i % N, 0, 'h789, 0, 'h3F);
        txn_const("ovf_dep", 0, 0, 'h789, 0, 'h3F, 4, 'hFF9, 0);
        txn_const("dep_to_max", 1, 0, 'h789, 0, 'h06, 0, 'hFFF, 0);
        txn_const("ovf_dep1", 2, 0, 'h789, 0, 'h01, 4, 'hFFF, 0);
        txn_const("ovf_xfr", 3, 3, 'h123, 'h789, 'h01, 4, 'h457, 0);

        // Three simultaneous deposits: served 0,1,2, four cycles apart.
        apply_reset();
        begin
            int cnt = 0;
            int last = -1;
            int exp_bal [3] = '{'h8CD, 'h8EC, 'h90B};
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                op_v[3*i +: 3]     = 3'd0;
                acct_v[AW*i +: AW] = AW'('h456);
                amt_v[MW*i +: MW]  = MW'('h1F);
            end
            req = 4'b0111;
            for (int n = 0; n < 40 && cnt < 3; n++) begin
                @(negedge clk);
                for (int i = 0; i < N; i++) begin
                    if (done[i] && cnt < 3) begin
                        check("conc_order", i, cnt);
                        check("conc_bal", int'(rsp_balance), exp_bal[cnt]);
                        if (last >= 0) check("conc_spacing", n - last, 4);
                        $display("txn concurrent term=%0d status=%0d bal=%0h", i, rsp_status, rsp_balance);
                        last = n;
                        cnt++;
                        req[i] = 1'b0;
                    end
                end
            end
            req = '0;
            check("conc_count", cnt, 3);
        end

        // Reset asserted during EXEC of a withdraw.
        apply_reset();
        begin
            int got = 0;
            int saw_done = 0;
            @(posedge clk); #1;
            op_v[3 +: 3]   = 3'd1;
            acct_v[AW +: AW] = AW'('h123);
            amt_v[MW +: MW]  = MW'('h10);
            req[1] = 1'b1;
            for (int n = 0; n < 10 && got == 0; n++) begin
                @(negedge clk);
                if (grant[1]) got = 1;
            end
            check("mid_grant_seen", got, 1);
            @(negedge clk);
            check("mid_busy", int'(busy), 1);
            rst = 1'b1;
            #1;
            check("mid_outputs", int'({grant, done, busy, rsp_status, rsp_balance, rsp_dst_balance}), 0);
            req[1] = 1'b0;
            repeat (2) @(negedge clk) saw_done |= int'(|done);
            rst = 1'b0;
            model_reset();
            repeat (3) @(negedge clk) saw_done |= int'(|done);
            check("mid_no_done", saw_done, 0);
            $display("txn reset-abort term=1 withdraw");
        end
        txn_const("after_rst_query", 0, 2, 'h123, 0, 0, 0, 'h457, 0);

        // Randomized transactions against the model.
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            int r = $urandom_range(0, 9);
            int o = (r < 8) ? (r % 4) : $urandom_range(4, 7);
            int amt = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63);
            txn_model("rand", $urandom_range(0, N - 1), o, pick_acct(), pick_acct(), amt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
